// File: rtl/mux_nx1_stream.sv
// rtl/mux_nx1_stream.sv - N-input stream multiplexer with manual and round-robin selection
// Registered single-stage output; full throughput with simultaneous drain and load.
module mux_nx1_stream #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  rr_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;

  // Round-robin scans from farthest to nearest so the channel closest after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        rr_idx = SELW'((int'(rr_ptr_q) + k) % N);
        if (in_valid[rr_idx]) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx;
        end
      end
    end
  end

  assign load_en = ~out_valid_q | out_ready;
  assign xfer    = rst_n & load_en & grant_vld;

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
